// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier requester and controller.
//   req_state_e : requester sequencing states
//   STEP_*      : step indices driven on `count`; the controller compares against the same values
package mult_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StAbort,
    StRecover,
    StResult
  } req_state_e;

  localparam logic [2:0] STEP_LAUNCH = 3'd0;
  localparam logic [2:0] STEP_ONE    = 3'd1;
  localparam logic [2:0] STEP_TWO    = 3'd2;
  localparam logic [2:0] STEP_THREE  = 3'd3;
  localparam logic [2:0] STEP_FOUR   = 3'd4;
  localparam logic [2:0] STEP_FINISH = 3'd5;

endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the multiplier requester.
// Optional feature macro: MULT_REQ_TIMEOUT_EN (adds the done_flag wait timer).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : load STEP_LAUNCH into the counter
//   inc          : advance one step, saturating at STEP_FINISH
//   wait_en      : waiting at STEP_FINISH without done_flag
//   count        : registered step index
//   timeout_hit  : last allowed wait cycle (always 0 without the macro)
module mult_step_counter import mult_pkg::*; #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       wait_en,
  output logic [2:0] count,
  output logic       timeout_hit
);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = STEP_LAUNCH;
    end else if (inc && (count_q != STEP_FINISH)) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= STEP_LAUNCH;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef MULT_REQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;

  // Counts consecutive waiting cycles; hit fires on the TIMEOUT-th one.
  assign wait_d      = wait_en ? wait_q + WaitW'(1) : '0;
  assign timeout_hit = wait_en && (wait_q == WaitW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_wait;
  assign unused_wait = wait_en ^ (TIMEOUT != 0);
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/mult_requester.sv
// Initiator-side sequencer for the shift-add multiplier controller.
// Optional feature macro: MULT_REQ_TIMEOUT_EN (sticky err_timeout after TIMEOUT wait cycles).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b  : upstream operand stream
//   abort                        : restart the current multiply (honoured at steps 1-4)
//   op_a, op_b                   : held operands to the datapath
//   start, count, changed        : registered controls to the controller
//   done_flag, mult_prod         : completion and product from controller/datapath
//   out_valid/out_ready/out_prod : downstream result stream
//   out_retried                  : result needed at least one restart
//   err_timeout                  : sticky timeout flag (0 without the macro)
module mult_requester import mult_pkg::*; #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               abort,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               start,
  output logic [2:0]         count,
  output logic               changed,
  input  logic               done_flag,
  input  logic [2*WIDTH-1:0] mult_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_retried,
  output logic               err_timeout
);

  req_state_e state_q, state_d;

  logic               in_ready_q, start_q, changed_q, out_valid_q, retried_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic [2*WIDTH-1:0] out_prod_q;
  logic               cnt_clr, cnt_inc, wait_en, timeout_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid && in_ready_q) state_d = StLaunch;
      StLaunch:  state_d = StRun;
      StRun: begin
        if (count == STEP_FINISH) begin
          if (done_flag || timeout_hit) state_d = StResult;
        end else if (abort && (count >= STEP_ONE) && (count <= STEP_FOUR)) begin
          state_d = StAbort;
        end
      end
      StAbort:   state_d = StRecover;
      StRecover: state_d = StRun;
      StResult:  if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Counter follows the next state so count is a clean register output.
  assign cnt_clr = (state_d == StIdle) || (state_d == StLaunch) || (state_d == StRecover);
  assign cnt_inc = (state_d == StRun);
  assign wait_en = (state_q == StRun) && (count == STEP_FINISH) && !done_flag;

  mult_step_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_step_counter (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .wait_en     (wait_en),
    .count       (count),
    .timeout_hit (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      changed_q   <= 1'b0;
      out_valid_q <= 1'b0;
      retried_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_prod_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == StIdle);
      start_q     <= (state_d == StLaunch);
      changed_q   <= (state_d == StAbort);
      out_valid_q <= (state_d == StResult);
      if ((state_q == StIdle) && (state_d == StLaunch)) begin
        op_a_q    <= in_a;
        op_b_q    <= in_b;
        retried_q <= 1'b0;
      end
      if (state_d == StRecover) retried_q <= 1'b1;
      // A timeout reaches RESULT without done_flag and reports a zero product.
      if ((state_q == StRun) && (state_d == StResult)) begin
        out_prod_q <= done_flag ? mult_prod : '0;
      end
    end
  end

`ifdef MULT_REQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign start       = start_q;
  assign changed     = changed_q;
  assign out_valid   = out_valid_q;
  assign out_retried = retried_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign out_prod    = out_prod_q;

endmodule

// File: tb/tb_mult_requester.sv
// Self-checking bench for mult_requester: directed vectors, a cycle model and literal checks.
module tb_mult_requester;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a, in_b;
  logic               abort;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               start;
  logic [2:0]         count;
  logic               changed;
  logic               done_flag;
  logic [2*WIDTH-1:0] mult_prod;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_retried;
  logic               err_timeout;
  logic               done_en;

  int n_tests = 0;
  int n_fail  = 0;

  mult_requester #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .abort       (abort),
    .op_a        (op_a),
    .op_b        (op_b),
    .start       (start),
    .count       (count),
    .changed     (changed),
    .done_flag   (done_flag),
    .mult_prod   (mult_prod),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_prod    (out_prod),
    .out_retried (out_retried),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Stand-in controller/datapath: done at the final step, product of the held operands.
  assign done_flag = done_en && (count == 3'd5);
  assign mult_prod = 8'(op_a) * 8'(op_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected outputs for the current cycle; stepped once per cycle from the inputs seen.
  bit m_valid = 0;
  bit m_busy, m_recover;
  int m_wait;
  int e_count, e_opa, e_opb, e_prod;
  bit e_in_ready, e_start, e_changed, e_out_valid, e_retried, e_err;

  always @(negedge clk) begin
    if (m_valid) begin
      bit post_reset;
      post_reset = !m_busy && !e_in_ready;
      check("in_ready",  in_ready,  e_in_ready);
      check("start",     start,     e_start);
      check("changed",   changed,   e_changed);
      check("out_valid", out_valid, e_out_valid);
      check("err",       err_timeout, e_err);
      if (m_busy ? !e_out_valid : post_reset) check("count", count, e_count);
      if (m_busy || post_reset) begin
        check("op_a", op_a, e_opa);
        check("op_b", op_b, e_opb);
      end
      if (e_out_valid || post_reset) begin
        check("out_prod",    out_prod,    e_prod);
        check("out_retried", out_retried, e_retried);
      end
    end
    // advance the model to the next cycle
    if (rst) begin
      m_valid = 1; m_busy = 0; m_recover = 0; m_wait = 0;
      e_in_ready = 0; e_start = 0; e_changed = 0; e_out_valid = 0;
      e_retried = 0; e_err = 0; e_count = 0; e_opa = 0; e_opb = 0; e_prod = 0;
    end else if (m_valid) begin
      if (e_out_valid) begin
        if (out_ready) begin
          e_out_valid = 0; e_in_ready = 1; m_busy = 0;
        end
      end else if (!m_busy) begin
        if (e_in_ready && in_valid) begin
          e_in_ready = 0; m_busy = 1; e_start = 1; e_count = 0;
          e_opa = int'(in_a); e_opb = int'(in_b); e_retried = 0;
        end else begin
          e_in_ready = 1;
        end
      end else if (e_start || m_recover) begin
        e_start = 0; m_recover = 0; e_count = 1;
      end else if (e_changed) begin
        e_changed = 0; e_count = 0; e_retried = 1; m_recover = 1;
      end else if (e_count == 5) begin
        if (done_flag) begin
          e_out_valid = 1; e_prod = e_opa * e_opb; m_wait = 0;
        end else begin
          m_wait++;
`ifdef MULT_REQ_TIMEOUT_EN
          if (m_wait == int'(TIMEOUT)) begin
            e_out_valid = 1; e_prod = 0; e_err = 1; m_wait = 0;
          end
`endif
        end
      end else if (abort) begin
        e_changed = 1;
      end else begin
        e_count++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the LAUNCH cycle (t+1) after the handshake edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check("send_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0;
    out_ready = 1'b1; done_en = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_count",    count,    0);
    rst = 1'b0;
    tick();
    check("in_ready_after_rst", in_ready, 1);

    // Basic multiply 3x5
    send(4'd3, 4'd5);
    check("basic_start", start, 1);
    check("basic_count0", count, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("basic_count", count, i);
    end
    tick();
    check("basic_valid",   out_valid,   1);
    check("basic_prod",    out_prod,    8'd15);
    check("basic_retried", out_retried, 0);
    tick();
    check("basic_idle_ready", in_ready, 1);

    // Back-pressure 6x6
    out_ready = 1'b0;
    send(4'd6, 4'd6);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_prod",  out_prod,  8'h24);
      check("bp_ready", in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    tick();

    // Abort at count 3, 7x9
    send(4'd7, 4'd9);
    tick(); tick(); tick();
    check("ab_count3", count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_changed", changed, 1);
    check("ab_hold",    count,   3);
    tick();
    check("ab_changed_low", changed, 0);
    check("ab_count0",      count,   0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("ab_count", count, i);
    end
    tick();
    check("ab_prod",    out_prod,    8'd63);
    check("ab_retried", out_retried, 1);
    tick();

    // Abort at count 5 is ignored, 2x11
    send(4'd2, 4'd11);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ign_valid",   out_valid,   1);
    check("ign_prod",    out_prod,    8'd22);
    check("ign_retried", out_retried, 0);
    tick();

    // Reset at count 2
    send(4'd4, 4'd4);
    tick(); tick();
    check("mid_count2", count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_in_ready", in_ready,  0);
    check("mid_valid",    out_valid, 0);
    check("mid_op_a",     op_a,      0);
    check("mid_count",    count,     0);
    tick();
    check("mid_ready_after", in_ready, 1);

`ifdef MULT_REQ_TIMEOUT_EN
    done_en = 1'b0;
    send(4'd5, 4'd3);
    repeat (5) tick();
    check("to_count5", count, 5);
    repeat (14) tick();
    check("to_not_yet", out_valid, 0);
    tick();
    check("to_valid", out_valid,   1);
    check("to_err",   err_timeout, 1);
    check("to_prod",  out_prod,    0);
    done_en = 1'b1;
    tick();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_requester.md
# mult_requester

Initiator-side sequencer for the shift-add multiplier controller. It accepts operand pairs from an upstream valid/ready stream, holds them stable for the datapath, and drives the controller's `start`, `count` and `changed` inputs in the step order the controller requires. It samples `done_flag` and the datapath product, and returns the result on a downstream valid/ready stream. It sits between the operand source and the controller/datapath pair, one multiply in flight at a time.

## Interface
- `WIDTH`, 4, operand width in bits
- `TIMEOUT`, 15, cycles to wait for `done_flag` after the final step (used only with the macro)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: requester can accept a pair
- `in_a`, `in_b` in WIDTH: operands
- `abort` in 1: upstream request to restart the current multiply
- `op_a`, `op_b` out WIDTH: held operands to the datapath
- `start` out 1: launch pulse to the controller
- `count` out 3: step index to the controller
- `changed` out 1: abort indication to the controller
- `done_flag` in 1: completion from the controller
- `mult_prod` in 2*WIDTH: product from the datapath
- `out_valid` out 1: result valid
- `out_ready` in 1: downstream accepts the result
- `out_prod` out 2*WIDTH: captured product
- `out_retried` out 1: the result needed at least one abort/restart
- `err_timeout` out 1: sticky timeout flag (macro only)

## Operation
- States: IDLE, LAUNCH, RUN, ABORT, RECOVER, RESULT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_a`/`in_b` into `op_a`/`op_b`, clear the retried flag, go to LAUNCH.
- **LAUNCH**
  - `start`=1, `count`=0, `in_ready`=0.
  - Next state is RUN with `count`=1.
- **RUN**
  - `count` increments by 1 each cycle, 1 through 5.
  - When `count`=5 and `done_flag`=1: capture `mult_prod` into `out_prod` and go to RESULT.
  - When `count`=5 and `done_flag`=0: hold `count` at 5 and keep waiting.
- **Abort**
  - `abort` is sampled in RUN while `count` is 1–4.
  - On `abort`, go to ABORT.
  - ABORT: `changed`=1 for exactly one cycle; `count` holds its value.
  - RECOVER: `changed`=0, `count`=0, retried flag set. Next state is RUN with `count`=1; this matches the controller's ERROR-to-S0 path.
  - Operands are not re-latched; the retry uses the held `op_a`/`op_b`.
- `abort` when `count`=5, or in any other state, is ignored.
- **RESULT**
  - `out_valid`=1, `out_prod` and `out_retried` held stable.
  - On `out_valid & out_ready`: go to IDLE.
  - `in_ready`=0 until IDLE is reached, so there is no back-to-back overlap.
- `start`, `changed` and `count` are registered outputs, so the controller sees them glitch-free.
- Reset values: `in_ready`=0, `start`=0, `changed`=0, `count`=0, `op_a`/`op_b`=0, `out_valid`=0, `out_prod`=0, `out_retried`=0, `err_timeout`=0; state IDLE.
- `in_ready` rises on the first cycle after `rst` deasserts.
- `rst` asserted mid-operation returns the block to IDLE on the next edge, drops `out_valid` and discards the held operands.

## Timing
- An input handshake at cycle t gives LAUNCH at t+1.
- `count` is 1..5 at t+2..t+6.
- `done_flag` is expected at t+6, so `out_valid` rises at t+7.
- Each abort adds 2 cycles (ABORT and RECOVER) plus the steps repeated from `count`=1.
- Minimum issue interval is 8 cycles with `out_ready` held high.

## Configuration
- `MULT_REQ_TIMEOUT_EN`
  - Defined: a wait counter runs while RUN holds `count`=5 without `done_flag`. After `TIMEOUT` cycles it sets sticky `err_timeout`, forces `out_prod`=0 and goes to RESULT. `err_timeout` clears only on `rst`.
  - Undefined: the block waits indefinitely, and `err_timeout` is tied to 0.

## Structure
- Shared package `mult_pkg`:
  - the requester state encoding;
  - the step constants `STEP_LAUNCH`=0 through `STEP_FINISH`=5, which the controller's step comparisons also use.
- One sub-module, `mult_step_counter`:
  - 3-bit counter with load-zero, increment and hold-at-5 controls;
  - under the macro, it also contains the timeout counter.

## Test plan
- **Basic multiply:** `in_a`=3, `in_b`=5 with `out_ready`=1 → `start` pulse at t+1, `count` 0,1,2,3,4,5, `out_prod`=15 at t+7, `out_retried`=0.
- **Back-pressure:** `out_ready`=0 for 4 cycles → `out_valid` and `out_prod`=0x24 (for 6×6) held stable, `in_ready`=0 throughout.
- **Abort:** `abort` at `count`=3 → `changed`=1 for one cycle, then `count`=0, then the sequence restarts at 1; final product correct and `out_retried`=1.
- **Ignored abort:** `abort` at `count`=5 → ignored, result delivered on schedule, `out_retried`=0.
- **Reset mid-run:** `rst` pulsed at `count`=2 → all outputs at reset values next cycle, `in_ready`=1 the cycle after `rst` deasserts.
- **Timeout (macro on, `TIMEOUT`=15):** `done_flag` tied 0 → `err_timeout`=1 and `out_valid`=1 with `out_prod`=0, 15 cycles after `count` reaches 5.
